// File: rtl/tag_pkg.sv
// Shared types and encodings for the store-side tag writer.
package tag_pkg;

  localparam int unsigned TAG_W = 6;

  // Size encodings match the load-side comparator select.
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALFWORD  = 2'd1,
    WORD      = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic {
    OP_SINGLE = 1'b0,
    OP_REGION = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } state_e;

  // Byte count covered by a single store-tag request.
  function automatic logic [2:0] single_bytes(input size_e sz);
    case (sz)
      BYTE:     single_bytes = 3'd1;
      HALFWORD: single_bytes = 3'd2;
      default:  single_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/tag_lane_mask.sv
// Lane-enable generator: from the byte offset within a word and the bytes
// still to tag, produce the lanes covered by this word and their count.
module tag_lane_mask #(
  parameter int unsigned LEN_W = 16
) (
  input  logic [1:0]       off,
  input  logic [LEN_W-1:0] remaining,
  output logic [3:0]       we,
  output logic [2:0]       n
);

  logic [2:0] avail;
  logic [3:0] base;

  // n = min(4 - off, remaining); lanes off..off+n-1 enabled.
  always_comb begin
    avail = 3'd4 - {1'b0, off};
    if (remaining < {{(LEN_W-3){1'b0}}, avail}) begin
      n = remaining[2:0];
    end else begin
      n = avail;
    end
    case (n)
      3'd1:    base = 4'b0001;
      3'd2:    base = 4'b0011;
      3'd3:    base = 4'b0111;
      3'd4:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    we = base << off;
  end

endmodule

// File: rtl/tag_writer.sv
// Store-side tag writer: accepts single store-tag or region-tag requests
// and issues lane-masked word writes to the tag SRAM, one per handshake.
module tag_writer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = tag_pkg::TAG_W,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                tm_valid,
  input  logic                tm_ready,
  output logic [ADDR_W-3:0]   tm_addr,
  output logic [3:0]          tm_we,
  output logic [4*TAG_W-1:0]  tm_wdata,
  output logic                done,
  output logic                err
);

  import tag_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;

  size_e             req_sz;
  logic [ADDR_W:0]   end_sum;
  logic              acc_err;
  logic              acc_zero;
  logic [LEN_W-1:0]  acc_len;

  logic [3:0]        lane_we;
  logic [2:0]        lane_n;
  logic              last_word;

  // Single ops are folded into the region datapath: an aligned access of
  // 1/2/4 bytes always fits in one word, so remaining = size in bytes.
  tag_lane_mask #(.LEN_W(LEN_W)) u_lane_mask (
    .off       (cur_addr[1:0]),
    .remaining (remaining),
    .we        (lane_we),
    .n         (lane_n)
  );

  assign last_word = (remaining == {{(LEN_W-3){1'b0}}, lane_n});

  // Request check: error conditions, zero-length region and byte count.
  always_comb begin
    req_sz   = size_e'(req_size);
    end_sum  = {1'b0, req_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, req_len};
    acc_err  = 1'b0;
    acc_zero = 1'b0;
    acc_len  = '0;
    if (op_e'(req_op) == OP_REGION) begin
      acc_err  = end_sum[ADDR_W] && (end_sum[ADDR_W-1:0] != '0);
      acc_zero = (req_len == '0);
      acc_len  = req_len;
    end else begin
      case (req_sz)
        SIZE_RSVD: acc_err = 1'b1;
        HALFWORD:  acc_err = req_addr[0];
        WORD:      acc_err = (req_addr[1:0] != 2'b00);
        default:   acc_err = 1'b0;
      endcase
      acc_len = {{(LEN_W-3){1'b0}}, single_bytes(req_sz)};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (acc_err || acc_zero) ? RESP : WRITE;
        end
      end
      WRITE: begin
        if (tm_ready && last_word) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and region walk: advance address and count per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      cur_addr  <= req_addr;
      remaining <= acc_len;
      tag_q     <= req_tag;
      err_q     <= acc_err;
    end else if (state_q == WRITE && tm_ready) begin
      cur_addr  <= cur_addr + {{(ADDR_W-3){1'b0}}, lane_n};
      remaining <= remaining - {{(LEN_W-3){1'b0}}, lane_n};
    end
  end

  // Outputs decoded from registered state; SRAM fields are zero when idle.
  always_comb begin
    req_ready = (state_q == IDLE);
    tm_valid  = (state_q == WRITE);
    tm_addr   = '0;
    tm_we     = '0;
    tm_wdata  = '0;
    if (tm_valid) begin
      tm_addr  = cur_addr[ADDR_W-1:2];
      tm_we    = lane_we;
      tm_wdata = {4{tag_q}};
    end
    done = (state_q == RESP);
    err  = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_tag_writer.sv
// Self-checking bench for tag_writer with a byte-level reference model.
module tb_tag_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [15:0] req_len = '0;
  logic [5:0]  req_tag = '0;
  logic        tm_valid;
  logic        tm_ready = 1'b1;
  logic [29:0] tm_addr;
  logic [3:0]  tm_we;
  logic [23:0] tm_wdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  tag_writer #(.ADDR_W(32), .TAG_W(6), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len), .req_tag(req_tag),
    .tm_valid(tm_valid), .tm_ready(tm_ready), .tm_addr(tm_addr), .tm_we(tm_we),
    .tm_wdata(tm_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: enumerate every tagged byte, group into words.
  logic        exp_err;
  logic [29:0] exp_addr[$];
  logic [3:0]  exp_we[$];

  task automatic model_req(input logic op, input logic [31:0] addr,
                           input logic [1:0] size, input logic [15:0] len);
    longint unsigned a, nb;
    logic [29:0] w;
    logic [3:0]  m;
    a = addr;
    nb = 0;
    exp_err = 1'b0;
    exp_addr.delete();
    exp_we.delete();
    if (op == 1'b0) begin
      if (size == 2'd3) exp_err = 1'b1;
      else if (size == 2'd1 && (a % 2) != 0) exp_err = 1'b1;
      else if (size == 2'd2 && (a % 4) != 0) exp_err = 1'b1;
      nb = longint'(1) << size;
    end else begin
      if (a + longint'(len) > 64'h1_0000_0000) exp_err = 1'b1;
      nb = len;
    end
    if (!exp_err) begin
      for (longint unsigned b = a; b < a + nb; b++) begin
        w = 30'(b / 4);
        m = 4'(1 << (b % 4));
        if (exp_addr.size() == 0 || exp_addr[exp_addr.size()-1] != w) begin
          exp_addr.push_back(w);
          exp_we.push_back(m);
        end else begin
          exp_we[exp_we.size()-1] = exp_we[exp_we.size()-1] | m;
        end
      end
    end
  endtask

  // Observations collected by run_req.
  logic [29:0] obs_addr[$];
  logic [3:0]  obs_we[$];
  logic [23:0] obs_wdata[$];
  logic        obs_err;
  int          obs_done_cycle;
  int          last_hs_cycle;
  int          stalled_cycles;
  int          unstable;
  logic        post_done;
  logic        post_ready;

  // Drive one request starting at a negedge while idle; record SRAM traffic.
  task automatic run_req(input logic op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [15:0] len, input logic [5:0] tag,
                         input int stall, input bit rnd);
    logic        prev_stall;
    logic [29:0] p_addr;
    logic [3:0]  p_we;
    logic [23:0] p_wdata;
    logic        rdy;
    obs_addr.delete(); obs_we.delete(); obs_wdata.delete();
    obs_err = 1'b0; obs_done_cycle = -1; last_hs_cycle = 0;
    stalled_cycles = 0; unstable = 0; post_done = 1'b0; post_ready = 1'b1;
    prev_stall = 1'b0; p_addr = '0; p_we = '0; p_wdata = '0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
    req_len = len; req_tag = tag;
    for (int cyc = 1; cyc <= 300 && obs_done_cycle < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      if (prev_stall && (tm_valid !== 1'b1 || tm_addr !== p_addr ||
                         tm_we !== p_we || tm_wdata !== p_wdata)) unstable++;
      rdy = (cyc <= stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      tm_ready = rdy;
      if (tm_valid === 1'b1) begin
        if (rdy) begin
          obs_addr.push_back(tm_addr);
          obs_we.push_back(tm_we);
          obs_wdata.push_back(tm_wdata);
          last_hs_cycle = cyc;
        end else begin
          stalled_cycles++;
        end
      end
      prev_stall = (tm_valid === 1'b1) && !rdy;
      p_addr = tm_addr; p_we = tm_we; p_wdata = tm_wdata;
      if (done === 1'b1) begin
        obs_done_cycle = cyc;
        obs_err = err;
      end
    end
    checks++;
    if (obs_done_cycle < 0) begin
      errors++;
      $display("FAIL timeout: done not seen within 300 cycles (addr=%h op=%0d)", addr, op);
    end else begin
      @(negedge clk);
      post_done = done;
      post_ready = req_ready;
    end
    tm_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, tm_valid, tm_addr, tm_we, tm_wdata, done, err} !==
        {1'b1, 1'b0, 30'd0, 4'd0, 24'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b addr=%h we=%b wdata=%h done=%b err=%b",
               req_ready, tm_valid, tm_addr, tm_we, tm_wdata, done, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    run_req(1'b0, 32'h1003, 2'd0, 16'd0, 6'h2A, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 1) begin
      errors++; $display("FAIL byte_count: got %0d writes, want 1", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 30'h400 || obs_we[0] !== 4'b1000 || obs_wdata[0] !== {4{6'h2A}}) begin
        errors++;
        $display("FAIL byte_write: got addr=%h we=%b wdata=%h, want 400 1000 %h",
                 obs_addr[0], obs_we[0], obs_wdata[0], {4{6'h2A}});
      end
    end
    checks++;
    if (obs_done_cycle !== 2 || obs_err !== 1'b0) begin
      errors++; $display("FAIL byte_done: got cycle %0d err %b, want 2 0", obs_done_cycle, obs_err);
    end
    checks++;
    if (post_done !== 1'b0 || post_ready !== 1'b1) begin
      errors++; $display("FAIL byte_pulse: after done got done=%b ready=%b, want 0 1", post_done, post_ready);
    end
  endtask

  task automatic test_errors;
    run_req(1'b0, 32'h1001, 2'd1, 16'd0, 6'h11, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 0 || obs_done_cycle !== 1 || obs_err !== 1'b1) begin
      errors++; $display("FAIL misaligned_half: writes=%0d cycle=%0d err=%b, want 0 1 1",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
    run_req(1'b0, 32'h2000, 2'd3, 16'd0, 6'h11, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 0 || obs_done_cycle !== 1 || obs_err !== 1'b1) begin
      errors++; $display("FAIL reserved_size: writes=%0d cycle=%0d err=%b, want 0 1 1",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
    run_req(1'b1, 32'h5000, 2'd0, 16'd0, 6'h11, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 0 || obs_done_cycle !== 1 || obs_err !== 1'b0) begin
      errors++; $display("FAIL region_len0: writes=%0d cycle=%0d err=%b, want 0 1 0",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
    run_req(1'b1, 32'hFFFF_FFFC, 2'd0, 16'd8, 6'h11, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 0 || obs_done_cycle !== 1 || obs_err !== 1'b1) begin
      errors++; $display("FAIL region_overflow: writes=%0d cycle=%0d err=%b, want 0 1 1",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
    run_req(1'b1, 32'hFFFF_FFFC, 2'd0, 16'd4, 6'h11, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 1 || obs_err !== 1'b0 || obs_done_cycle !== 2) begin
      errors++; $display("FAIL region_top_exact: writes=%0d cycle=%0d err=%b, want 1 2 0",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
  endtask

  task automatic test_region;
    logic [29:0] wa[3];
    logic [3:0]  ww[3];
    wa[0] = 30'h800; wa[1] = 30'h801; wa[2] = 30'h802;
    ww[0] = 4'b1100; ww[1] = 4'b1111; ww[2] = 4'b0111;
    run_req(1'b1, 32'h2002, 2'd0, 16'd9, 6'h15, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 3) begin
      errors++; $display("FAIL region_count: got %0d writes, want 3", obs_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_addr[i] !== wa[i] || obs_we[i] !== ww[i] || obs_wdata[i] !== {4{6'h15}}) begin
          errors++;
          $display("FAIL region_write%0d: got addr=%h we=%b wdata=%h, want %h %b %h",
                   i, obs_addr[i], obs_we[i], obs_wdata[i], wa[i], ww[i], {4{6'h15}});
        end
      end
    end
    checks++;
    if (obs_done_cycle !== 4 || obs_err !== 1'b0) begin
      errors++; $display("FAIL region_done: got cycle %0d err %b, want 4 0", obs_done_cycle, obs_err);
    end
  endtask

  task automatic test_stall;
    run_req(1'b0, 32'h3000, 2'd2, 16'd0, 6'h3C, 5, 1'b0);
    checks++;
    if (stalled_cycles !== 5 || unstable !== 0) begin
      errors++; $display("FAIL stall_hold: stalled=%0d unstable=%0d, want 5 0", stalled_cycles, unstable);
    end
    checks++;
    if (obs_addr.size() !== 1 || obs_addr[0] !== 30'hC00 || obs_we[0] !== 4'b1111) begin
      errors++; $display("FAIL stall_write: writes=%0d, want one write C00/1111", obs_addr.size());
    end
    checks++;
    if (obs_done_cycle !== 7) begin
      errors++; $display("FAIL stall_done: got cycle %0d, want 7", obs_done_cycle);
    end
  endtask

  task automatic test_reset_mid;
    int bad_done;
    bad_done = 0;
    tm_ready = 1'b1;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0; req_len = 16'd16; req_tag = 6'h07;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tm_valid !== 1'b1 || tm_addr !== 30'd2) begin
      errors++; $display("FAIL midreset_pre: valid=%b addr=%h, want 1 2", tm_valid, tm_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, tm_valid, tm_addr, tm_we, tm_wdata, done, err} !==
        {1'b1, 1'b0, 30'd0, 4'd0, 24'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: ready=%b valid=%b addr=%h we=%b wdata=%h done=%b",
               req_ready, tm_valid, tm_addr, tm_we, tm_wdata, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tm_valid !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done !== 0) begin
      errors++; $display("FAIL midreset_nodone: %0d cycles with done/valid, want 0", bad_done);
    end
    run_req(1'b0, 32'h0000_0012, 2'd1, 16'd0, 6'h2F, 0, 1'b0);
    checks++;
    if (obs_addr.size() !== 1 || obs_addr[0] !== 30'h4 || obs_we[0] !== 4'b1100 ||
        obs_done_cycle !== 2 || obs_err !== 1'b0) begin
      errors++; $display("FAIL midreset_next: writes=%0d cycle=%0d err=%b, want 1 2 0",
                         obs_addr.size(), obs_done_cycle, obs_err);
    end
  endtask

  task automatic test_random;
    logic        op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [15:0] len;
    logic [5:0]  tag;
    int          exp_cycle;
    int          nw;
    for (int it = 0; it < 60; it++) begin
      op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       addr = $urandom;
        1:       addr = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
        default: addr = 32'($urandom_range(0, 4095));
      endcase
      size = 2'($urandom_range(0, 3));
      len  = 16'($urandom_range(0, 40));
      tag  = 6'($urandom_range(0, 63));
      model_req(op, addr, size, len);
      run_req(op, addr, size, len, tag, 0, 1'b1);
      checks++;
      if (obs_err !== exp_err) begin
        errors++; $display("FAIL rand_err[%0d]: got %b, want %b (op=%0d addr=%h size=%0d len=%0d)",
                           it, obs_err, exp_err, op, addr, size, len);
      end
      checks++;
      if (obs_addr.size() !== exp_addr.size()) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d writes, want %0d", it,
                           obs_addr.size(), exp_addr.size());
      end
      nw = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < nw; i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_we[i] !== exp_we[i] || obs_wdata[i] !== {4{tag}}) begin
          errors++;
          $display("FAIL rand_write[%0d.%0d]: got %h/%b/%h, want %h/%b/%h", it, i,
                   obs_addr[i], obs_we[i], obs_wdata[i], exp_addr[i], exp_we[i], {4{tag}});
        end
      end
      exp_cycle = (exp_addr.size() == 0) ? 1 : last_hs_cycle + 1;
      checks++;
      if (obs_done_cycle !== exp_cycle || unstable !== 0 || post_done !== 1'b0 || post_ready !== 1'b1) begin
        errors++; $display("FAIL rand_timing[%0d]: done cycle %0d want %0d, unstable %0d, post %b%b want 01",
                           it, obs_done_cycle, exp_cycle, unstable, post_done, post_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_errors();
    test_region();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
